// File: rtl/mindfocus_pkg.sv
// Shared types and constants for the MindFocus round engine.
package mindfocus_pkg;

  // FSM state codes, also exported on db_estado
  typedef enum logic [3:0] {
    ST_OCIOSO  = 4'd0,
    ST_SORTEIA = 4'd1,
    ST_SOLTA   = 4'd2,
    ST_ESPERA  = 4'd3,
    ST_AVALIA  = 4'd4,
    ST_PROXIMA = 4'd5,
    ST_FIM     = 4'd6
  } estado_t;

  localparam int unsigned      LFSR_W    = 16;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam int unsigned CNT_W   = 8;
  localparam logic [7:0]  SAT_MAX = 8'hFF;

  // Packed score snapshot carried between scoring and the output registers
  typedef struct packed {
    logic [CNT_W-1:0] acertos;
    logic [CNT_W-1:0] erros;
  } placar_t;

  // Saturating 8-bit increment
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // One right-shift Galois step; a nonzero state never maps to zero
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/mindfocus_lfsr.sv
// Free-running 16-bit Galois LFSR with reseed from a cycle counter.
// Exposes only the low OUT_W bits needed for target selection.
module mindfocus_lfsr
  import mindfocus_pkg::*;
#(
  parameter int unsigned OUT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reload,
  output logic [OUT_W-1:0] bits_baixos
);

  logic [LFSR_W-1:0] valor_q;
  logic [LFSR_W-1:0] ciclos_q;
  logic [LFSR_W-1:0] mix_c;

  assign mix_c       = valor_q ^ ciclos_q;
  assign bits_baixos = valor_q[OUT_W-1:0];

  // Step every cycle; on reload mix in the cycle count, never allowing zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q  <= LFSR_SEED;
      ciclos_q <= '0;
    end else begin
      ciclos_q <= ciclos_q + LFSR_W'(1);
      if (reload) begin
        valor_q <= (mix_c == '0) ? LFSR_W'(1) : mix_c;
      end else begin
        valor_q <= lfsr_step(valor_q);
      end
    end
  end

endmodule

// File: rtl/mindfocus_round_engine.sv
// MindFocus round engine: draws a target, waits for a press, scores
// hit / wrong press / timeout over N_RODADAS rounds.
// Optional: MINDFOCUS_NO_REPEAT_EN forbids equal consecutive targets.
module mindfocus_round_engine
  import mindfocus_pkg::*;
#(
  parameter int unsigned N_BOTOES  = 4,
  parameter int unsigned N_RODADAS = 3,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] alvo,
  output logic [7:0]          acertos,
  output logic [7:0]          erros,
  output logic [7:0]          rodada,
  output logic [15:0]         tempo_reacao,
  output logic                pronto,
  output logic                fim,
  output logic [3:0]          db_estado
);

  localparam int unsigned K     = $clog2(N_BOTOES);
  // One extra bit so N_BOTOES itself can encode "no previous target"
  localparam int unsigned IDX_W = K + 1;

  estado_t             estado;
  logic [N_BOTOES-1:0] sync1_q, sync2_q;
  logic                any_q;
  logic                press_c;
  logic [N_BOTOES-1:0] press_vec_q;
  logic [N_BOTOES-1:0] tgt_q;
  logic [31:0]         rt_q;
  logic [K-1:0]        lfsr_bits;
  logic                reload_c;
  logic [IDX_W-1:0]    raw_c, draw_c;
  logic [N_BOTOES-1:0] tgt_c;
  logic                hit_c;
  placar_t             placar_c;
`ifdef MINDFOCUS_NO_REPEAT_EN
  logic [IDX_W-1:0]    prev_idx_q;
`endif

  assign reload_c = iniciar && ((estado == ST_OCIOSO) || (estado == ST_FIM));

  mindfocus_lfsr #(.OUT_W(K)) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .reload     (reload_c),
    .bits_baixos(lfsr_bits)
  );

  // Two-flop synchroniser plus previous OR for rising-edge press detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= botoes;
      sync2_q <= sync1_q;
      any_q   <= |sync2_q;
    end
  end

  assign press_c = (|sync2_q) & ~any_q;

  // Target index: fold into range, optionally step past the previous target
  always_comb begin
    raw_c = IDX_W'(lfsr_bits);
    if (raw_c >= IDX_W'(N_BOTOES)) begin
      raw_c = raw_c - IDX_W'(N_BOTOES);
    end
    draw_c = raw_c;
`ifdef MINDFOCUS_NO_REPEAT_EN
    if (raw_c == prev_idx_q) begin
      draw_c = (raw_c == IDX_W'(N_BOTOES - 1)) ? '0 : raw_c + IDX_W'(1);
    end
`endif
    tgt_c = N_BOTOES'(1) << draw_c;
  end

  // Scoring of the current round; a timeout leaves press_vec at zero so it never matches
  always_comb begin
    hit_c            = (press_vec_q == tgt_q);
    placar_c.acertos = hit_c ? sat_inc(acertos) : acertos;
    placar_c.erros   = hit_c ? erros : sat_inc(erros);
  end

  assign db_estado = estado;

  // Round sequencing with registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= ST_OCIOSO;
      alvo         <= '0;
      tgt_q        <= '0;
      press_vec_q  <= '0;
      rt_q         <= '0;
      acertos      <= '0;
      erros        <= '0;
      rodada       <= '0;
      tempo_reacao <= '0;
      pronto       <= 1'b1;
      fim          <= 1'b0;
`ifdef MINDFOCUS_NO_REPEAT_EN
      prev_idx_q   <= IDX_W'(N_BOTOES);
`endif
    end else begin
      fim <= 1'b0;
      case (estado)
        ST_OCIOSO, ST_FIM: begin
          alvo <= '0;
          if (iniciar) begin
            acertos      <= '0;
            erros        <= '0;
            rodada       <= '0;
            tempo_reacao <= '0;
            pronto       <= 1'b0;
            estado       <= ST_SORTEIA;
          end
        end
        ST_SORTEIA: begin
          tgt_q  <= tgt_c;
          alvo   <= tgt_c;
`ifdef MINDFOCUS_NO_REPEAT_EN
          prev_idx_q <= draw_c;
`endif
          estado <= ST_SOLTA;
        end
        ST_SOLTA: begin
          if (sync2_q == '0) begin
            rt_q   <= '0;
            estado <= ST_ESPERA;
          end
        end
        ST_ESPERA: begin
          if (press_c) begin
            press_vec_q <= sync2_q;
            alvo        <= '0;
            estado      <= ST_AVALIA;
          end else if (rt_q == 32'(TIMEOUT - 1)) begin
            press_vec_q <= '0;
            alvo        <= '0;
            estado      <= ST_AVALIA;
          end else begin
            rt_q <= rt_q + 32'd1;
          end
        end
        ST_AVALIA: begin
          acertos      <= placar_c.acertos;
          erros        <= placar_c.erros;
          tempo_reacao <= (rt_q > 32'h0000_FFFF) ? 16'hFFFF : rt_q[15:0];
          if (rodada == 8'(N_RODADAS - 1)) begin
            fim    <= 1'b1;
            pronto <= 1'b1;
            estado <= ST_FIM;
          end else begin
            estado <= ST_PROXIMA;
          end
        end
        ST_PROXIMA: begin
          rodada <= sat_inc(rodada);
          estado <= ST_SORTEIA;
        end
        default: begin
          alvo   <= '0;
          pronto <= 1'b1;
          estado <= ST_OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mindfocus_round_engine.sv
// Scoreboard bench for mindfocus_round_engine (N_BOTOES=4, N_RODADAS=3, TIMEOUT=20).
module tb_mindfocus_round_engine;

  localparam int N  = 4;
  localparam int R  = 3;
  localparam int TO = 20;
  localparam int KB = $clog2(N);

  localparam int K_HIT = 0, K_WRONG = 1, K_MULTI = 2, K_TIMEOUT = 3;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  e;
    logic [7:0]  r;
    logic [15:0] t;
    logic        last;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          iniciar;
  logic [N-1:0]  botoes;
  logic [N-1:0]  alvo;
  logic [7:0]    acertos, erros, rodada;
  logic [15:0]   tempo_reacao;
  logic          pronto, fim;
  logic [3:0]    db_estado;

  mindfocus_round_engine #(.N_BOTOES(N), .N_RODADAS(R), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .botoes      (botoes),
    .alvo        (alvo),
    .acertos     (acertos),
    .erros       (erros),
    .rodada      (rodada),
    .tempo_reacao(tempo_reacao),
    .pronto      (pronto),
    .fim         (fim),
    .db_estado   (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_miscmp = 0;
  int   fim_cnt = 0;
  int   games_done = 0;
  int   cur_round = 0;
  logic [7:0] exp_a = '0;
  logic [7:0] exp_e = '0;
  logic m_idle = 1'b1;
  exp_t sb[$];
`ifdef MINDFOCUS_NO_REPEAT_EN
  int       m_prev_idx = N;
  logic [N-1:0] last_alvo = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miscmp++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Reference random source: the same generator the player sees
  logic [15:0] m_lfsr, m_lfsr_prev, m_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
      m_cnt       <= '0;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_cnt       <= m_cnt + 16'd1;
      if (iniciar && m_idle)
        m_lfsr <= ((m_lfsr ^ m_cnt) == 16'h0) ? 16'h0001 : (m_lfsr ^ m_cnt);
      else
        m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // Pop and compare one scoreboard entry the cycle after each AVALIA
  logic pend = 1'b0;
  logic fim_low_chk = 1'b0;
  always @(negedge clock) begin
    exp_t x;
    if (!reset) begin
      pend = 1'b0;
      fim_low_chk = 1'b0;
    end else begin
      if (fim_low_chk) begin
        check("fim_width", 32'(fim), 32'd0);
        fim_low_chk = 1'b0;
      end
      if (pend) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          x = sb.pop_front();
          check("acertos", 32'(acertos), 32'(x.a));
          check("erros", 32'(erros), 32'(x.e));
          check("tempo_reacao", 32'(tempo_reacao), 32'(x.t));
          check("rodada", 32'(rodada), 32'(x.r));
          check("fim", 32'(fim), 32'(x.last));
          if (x.last) begin
            check("pronto_fim", 32'(pronto), 32'd1);
            fim_low_chk = 1'b1;
          end
        end
      end
      pend = (db_estado == 4'd4);
      if (fim) fim_cnt++;
    end
  end

  task automatic get_target(output logic [N-1:0] tgt);
    int waited;
    int idx;
    waited = 0;
    while (alvo == '0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("alvo_wait", 32'(waited < 100), 32'd1);
    idx = int'(m_lfsr_prev) % (1 << KB);
    if (idx >= N) idx -= N;
`ifdef MINDFOCUS_NO_REPEAT_EN
    if (idx == m_prev_idx) idx = (idx + 1) % N;
    m_prev_idx = idx;
    if (last_alvo != '0) check("no_repeat", 32'(alvo != last_alvo), 32'd1);
    last_alvo = alvo;
`endif
    tgt = N'(1) << idx;
    check("alvo", 32'(alvo), 32'(tgt));
    check("pronto_busy", 32'(pronto), 32'd0);
  endtask

  task automatic finish_round(input int kind, input int d, input logic [N-1:0] tgt, input int exp_rt);
    logic [N-1:0] other, btn;
    exp_t x;
    int waited;
    other = {tgt[N-2:0], tgt[N-1]};
    case (kind)
      K_HIT:   btn = tgt;
      K_WRONG: btn = other;
      K_MULTI: btn = tgt | other;
      default: btn = '0;
    endcase
    if (kind == K_HIT) exp_a = sat8(exp_a);
    else               exp_e = sat8(exp_e);
    x.a    = exp_a;
    x.e    = exp_e;
    x.r    = 8'(cur_round);
    x.t    = (kind == K_TIMEOUT) ? 16'(TO - 1) : 16'(exp_rt);
    x.last = (cur_round == R - 1);
    sb.push_back(x);
    if (kind != K_TIMEOUT) begin
      repeat (d - 1) @(negedge clock);
      botoes = btn;
    end
    waited = 0;
    while (alvo != '0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("score_wait", 32'(waited < 200), 32'd1);
    botoes = '0;
    cur_round++;
  endtask

  task automatic play(input int kind, input int d);
    logic [N-1:0] t;
    get_target(t);
    finish_round(kind, d, t, d);
  endtask

  task automatic start_game();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar   = 1'b0;
    m_idle    = 1'b0;
    exp_a     = '0;
    exp_e     = '0;
    cur_round = 0;
  endtask

  task automatic end_game();
    repeat (3) @(negedge clock);
    m_idle = 1'b1;
    games_done++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] t;
    reset = 1'b0; iniciar = 1'b0; botoes = '0;
    repeat (3) @(negedge clock);
    check("rst_alvo", 32'(alvo), 32'd0);
    check("rst_acertos", 32'(acertos), 32'd0);
    check("rst_erros", 32'(erros), 32'd0);
    check("rst_rodada", 32'(rodada), 32'd0);
    check("rst_tempo", 32'(tempo_reacao), 32'd0);
    check("rst_fim", 32'(fim), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd1);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Game A: two hits then a timeout
    start_game();
    play(K_HIT, 3);
    play(K_HIT, 5);
    play(K_TIMEOUT, 1);
    end_game();

    // Game B: iniciar mid-game is ignored; wrong, multi, hit
    start_game();
    get_target(t);
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    finish_round(K_WRONG, 7, t, 9);
    play(K_MULTI, 2);
    play(K_HIT, 9);
    end_game();

    // Game C: button held through the draw stays in SOLTA
    botoes = 4'b0010;
    start_game();
    get_target(t);
    repeat (8) @(negedge clock);
    check("solta_hold", 32'(db_estado), 32'd2);
    botoes = '0;
    repeat (4) @(negedge clock);
    finish_round(K_HIT, 1, t, 3);
    play(K_WRONG, 2);
    play(K_HIT, 4);
    end_game();

    // Game D: reset during ESPERA of round 1
    start_game();
    play(K_HIT, 2);
    get_target(t);
    repeat (3) @(negedge clock);
    check("pre_rst_estado", 32'(db_estado), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_alvo", 32'(alvo), 32'd0);
    check("arst_acertos", 32'(acertos), 32'd0);
    check("arst_erros", 32'(erros), 32'd0);
    check("arst_rodada", 32'(rodada), 32'd0);
    check("arst_tempo", 32'(tempo_reacao), 32'd0);
    check("arst_fim", 32'(fim), 32'd0);
    check("arst_pronto", 32'(pronto), 32'd1);
    check("arst_estado", 32'(db_estado), 32'd0);
    sb.delete();
    m_idle = 1'b1;
`ifdef MINDFOCUS_NO_REPEAT_EN
    m_prev_idx = N;
    last_alvo  = '0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Randomised games
    for (int g = 0; g < 30; g++) begin
      start_game();
      for (int r = 0; r < R; r++) begin
        play(int'($urandom_range(0, 3)), int'($urandom_range(1, 15)));
      end
      end_game();
    end

    check("fim_count", 32'(fim_cnt), 32'(games_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
